// File: rtl/cache_maint_sequencer_pkg.sv
// Shared types for the cache maintenance sequencer: request opcodes and FSM states.
// Op bit 0 selects a flush phase and bit 1 a clear phase.
package cache_maint_sequencer_pkg;

    typedef enum logic [1:0] {
        MAINT_NOP         = 2'b00,
        MAINT_FLUSH       = 2'b01,
        MAINT_CLEAR       = 2'b10,
        MAINT_FLUSH_CLEAR = 2'b11
    } maint_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FLUSH = 2'b01,
        ST_CLEAR = 2'b10,
        ST_DONE  = 2'b11
    } maint_state_t;

    function automatic logic op_has_flush(input maint_op_t op);
        return op[0];
    endfunction

    function automatic logic op_has_clear(input maint_op_t op);
        return op[1];
    endfunction

endpackage

// File: rtl/cache_maint_sequencer_lsb_priority_enc.sv
// Combinational lowest-set-bit encoder: index of the lowest set bit plus a valid flag.
module lsb_priority_enc #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     in_vec,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_vec[i]) begin
                idx = IDX_W'(i);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_maint_sequencer.sv
// Walks the masked caches lowest-index first, issuing flush and/or clear level requests
// with an optional per-phase timeout; pulses done_pulse for one cycle when finished.
module cache_maint_sequencer
    import cache_maint_sequencer_pkg::*;
#(
    parameter int NUM_CACHES = 2,
    parameter int TIMEOUT_W  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [NUM_CACHES-1:0] req_mask,
    input  logic [TIMEOUT_W-1:0]  timeout_cycles,
    output logic [NUM_CACHES-1:0] flush_o,
    output logic [NUM_CACHES-1:0] clear_o,
    input  logic [NUM_CACHES-1:0] flush_done_i,
    input  logic [NUM_CACHES-1:0] clear_done_i,
    output logic                  busy,
    output logic                  done_pulse,
    output logic [NUM_CACHES-1:0] err_mask
);

    localparam int IDX_W = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;

    maint_state_t          state, state_nxt;
    maint_op_t             op_q;
    logic [NUM_CACHES-1:0] pending, pending_nxt;
    logic [TIMEOUT_W-1:0]  limit, cnt;
    logic [IDX_W-1:0]      cur;
    logic                  cur_vld;
    logic [NUM_CACHES-1:0] cur_oh;
    logic [NUM_CACHES-1:0] err_set;
    logic                  accept, cur_done, expire, phase_end, retire;

    lsb_priority_enc #(
        .N     (NUM_CACHES),
        .IDX_W (IDX_W)
    ) u_enc (
        .in_vec (pending),
        .idx    (cur),
        .vld    (cur_vld)
    );

    assign cur_oh     = cur_vld ? (NUM_CACHES'(1) << cur) : '0;
    assign req_ready  = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign done_pulse = (state == ST_DONE);
    assign accept     = req_valid && req_ready;

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        flush_o     = '0;
        clear_o     = '0;
        cur_done    = 1'b0;
        expire      = 1'b0;
        phase_end   = 1'b0;
        retire      = 1'b0;
        err_set     = '0;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    pending_nxt = req_mask;
                    if (maint_op_t'(req_op) == MAINT_NOP || req_mask == '0)
                        state_nxt = ST_DONE;
                    else if (op_has_flush(maint_op_t'(req_op)))
                        state_nxt = ST_FLUSH;
                    else
                        state_nxt = ST_CLEAR;
                end
            end
            ST_FLUSH, ST_CLEAR: begin
                if (state == ST_FLUSH) begin
                    flush_o  = cur_oh;
                    cur_done = |(flush_done_i & cur_oh);
                end else begin
                    clear_o  = cur_oh;
                    cur_done = |(clear_done_i & cur_oh);
                end
                // A done arriving in the expiry cycle wins over the timeout.
                expire    = cur_vld && !cur_done && (limit != '0) &&
                            (cnt == limit - TIMEOUT_W'(1));
                phase_end = cur_done || expire;
                err_set   = expire ? cur_oh : '0;
                if (state == ST_FLUSH && cur_done && op_has_clear(op_q))
                    state_nxt = ST_CLEAR;
                else if (phase_end)
                    retire = 1'b1;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase

        // A timed-out flush retires the cache directly, skipping its clear.
        if (retire) begin
            pending_nxt = pending & ~cur_oh;
            if (pending_nxt != '0)
                state_nxt = op_has_flush(op_q) ? ST_FLUSH : ST_CLEAR;
            else
                state_nxt = ST_DONE;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_IDLE;
            op_q     <= MAINT_NOP;
            pending  <= '0;
            limit    <= '0;
            cnt      <= '0;
            err_mask <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            if (accept) begin
                op_q     <= maint_op_t'(req_op);
                limit    <= timeout_cycles;
                err_mask <= '0;
            end else begin
                err_mask <= err_mask | err_set;
            end
            // Counter restarts on every phase entry and saturates rather than wrapping.
            if ((state != ST_FLUSH && state != ST_CLEAR) || phase_end)
                cnt <= '0;
            else if (cnt != '1)
                cnt <= cnt + TIMEOUT_W'(1);
        end
    end

endmodule

// File: tb/tb_cache_maint_sequencer.sv
// Bench for cache_maint_sequencer: a work-queue reference model checked every cycle,
// plus directed scenarios with literal expectations and randomized traffic.
module tb_cache_maint_sequencer;

    localparam int NC = 2;
    localparam int TW = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [NC-1:0] req_mask;
    logic [TW-1:0] timeout_cycles;
    logic [NC-1:0] flush_o, clear_o, flush_done_i, clear_done_i, err_mask;
    logic          busy, done_pulse;

    cache_maint_sequencer #(.NUM_CACHES(NC), .TIMEOUT_W(TW)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_mask       (req_mask),
        .timeout_cycles (timeout_cycles),
        .flush_o        (flush_o),
        .clear_o        (clear_o),
        .flush_done_i   (flush_done_i),
        .clear_done_i   (clear_done_i),
        .busy           (busy),
        .done_pulse     (done_pulse),
        .err_mask       (err_mask)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of (cache, phase) work items built at accept time.
    typedef struct {
        int c;
        bit clr;
    } step_t;

    step_t         q[$];
    bit            m_fin;
    int            m_t;
    int            m_lim;
    logic [NC-1:0] m_err;
    bit            run_cmp = 1'b0;

    function automatic void model_reset();
        q.delete();
        m_fin = 1'b0;
        m_t   = 0;
        m_lim = 0;
        m_err = '0;
    endfunction

    function automatic void model_advance();
        step_t s;
        bit    d;
        if (m_fin) begin
            m_fin = 1'b0;
        end else if (q.size() == 0) begin
            if (req_valid) begin
                m_err = '0;
                m_lim = int'(timeout_cycles);
                m_t   = 0;
                if (req_op != 2'b00) begin
                    for (int c = 0; c < NC; c++) begin
                        if (req_mask[c]) begin
                            if (req_op[0]) q.push_back('{c, 1'b0});
                            if (req_op[1]) q.push_back('{c, 1'b1});
                        end
                    end
                end
                if (q.size() == 0) m_fin = 1'b1;
            end
        end else begin
            s = q[0];
            d = s.clr ? clear_done_i[s.c] : flush_done_i[s.c];
            if (d) begin
                void'(q.pop_front());
                m_t = 0;
            end else if (m_lim != 0 && m_t == m_lim - 1) begin
                m_err[s.c] = 1'b1;
                void'(q.pop_front());
                if (!s.clr && q.size() > 0 && q[0].c == s.c && q[0].clr)
                    void'(q.pop_front());
                m_t = 0;
            end else begin
                m_t++;
            end
            if (q.size() == 0) m_fin = 1'b1;
        end
    endfunction

    always @(negedge CLK) begin
        logic [NC-1:0] ef, ec;
        logic          act;
        if (run_cmp && !RST) begin
            ef  = '0;
            ec  = '0;
            act = m_fin || (q.size() > 0);
            if (!m_fin && q.size() > 0) begin
                if (q[0].clr) ec[q[0].c] = 1'b1;
                else          ef[q[0].c] = 1'b1;
            end
            chk("flush_o",    32'(flush_o),    32'(ef));
            chk("clear_o",    32'(clear_o),    32'(ec));
            chk("busy",       32'(busy),       32'(act));
            chk("req_ready",  32'(req_ready),  32'(!act));
            chk("done_pulse", 32'(done_pulse), 32'(m_fin));
            chk("err_mask",   32'(err_mask),   32'(m_err));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        model_advance();
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [1:0] msk,
                         input logic [TW-1:0] tc, input logic [1:0] fd, input logic [1:0] cd);
        req_valid      = v;
        req_op         = op;
        req_mask       = msk;
        timeout_cycles = tc;
        flush_done_i   = fd;
        clear_done_i   = cd;
    endtask

    logic [1:0] exp_f40 [5] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b00};
    logic [1:0] exp_c40 [5] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    logic       exp_d40 [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        int f0, c0, f1, c1, hi, done_at;
        bit seen;
        RST = 1'b1;
        drive(1'b0, 2'b00, 2'b00, '0, 2'b00, 2'b00);
        model_reset();
        #1;
        chk("rst_busy",  32'(busy),       32'd0);
        chk("rst_ready", 32'(req_ready),  32'd1);
        chk("rst_flush", 32'(flush_o),    32'd0);
        chk("rst_clear", 32'(clear_o),    32'd0);
        chk("rst_done",  32'(done_pulse), 32'd0);
        chk("rst_err",   32'(err_mask),   32'd0);
        @(negedge CLK);
        RST = 1'b0;
        run_cmp = 1'b1;
        tick();

        // All done inputs tied high: one cycle per phase.
        drive(1'b1, 2'b11, 2'b11, '0, 2'b11, 2'b11);
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("seq_flush", 32'(flush_o),    32'(exp_f40[k]));
            chk("seq_clear", 32'(clear_o),    32'(exp_c40[k]));
            chk("seq_done",  32'(done_pulse), 32'(exp_d40[k]));
            tick();
        end
        chk("seq_err", 32'(err_mask), 32'd0);

        // I$-only flush with a slow completion.
        drive(1'b1, 2'b01, 2'b10, '0, 2'b00, 2'b00);
        tick();
        req_valid = 1'b0;
        hi = 0; f0 = 0; seen = 1'b0; done_at = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            if (done_pulse) begin
                seen = 1'b1;
                done_at = k;
            end else begin
                if (flush_o[1]) hi++;
                if (flush_o[0]) f0++;
                if (hi == 7) flush_done_i = 2'b10;
                tick();
            end
        end
        chk("slow_seen",   32'(seen),    32'd1);
        chk("slow_len",    32'(hi),      32'd7);
        chk("slow_f0",     32'(f0),      32'd0);
        chk("slow_doneat", 32'(done_at), 32'd8);
        flush_done_i = 2'b00;
        tick();

        // D$ flush never completes; timeout of 4 skips its clear.
        drive(1'b1, 2'b11, 2'b11, TW'(4), 2'b10, 2'b11);
        tick();
        req_valid = 1'b0;
        f0 = 0; c0 = 0; f1 = 0; c1 = 0; seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (done_pulse) begin
                seen = 1'b1;
                chk("to_err_done", 32'(err_mask), 32'd1);
            end else begin
                f0 += int'(flush_o[0]);
                c0 += int'(clear_o[0]);
                f1 += int'(flush_o[1]);
                c1 += int'(clear_o[1]);
            end
            tick();
        end
        chk("to_seen", 32'(seen), 32'd1);
        chk("to_f0",   32'(f0),   32'd4);
        chk("to_c0",   32'(c0),   32'd0);
        chk("to_f1",   32'(f1),   32'd1);
        chk("to_c1",   32'(c1),   32'd1);
        chk("to_hold", 32'(err_mask), 32'd1);

        // Nothing to do: done on the cycle after accept.
        for (int k = 0; k < 2; k++) begin
            if (k == 0) drive(1'b1, 2'b00, 2'b11, '0, 2'b11, 2'b11);
            else        drive(1'b1, 2'b11, 2'b00, '0, 2'b11, 2'b11);
            tick();
            req_valid = 1'b0;
            chk("nop_done",  32'(done_pulse), 32'd1);
            chk("nop_flush", 32'(flush_o),    32'd0);
            chk("nop_clear", 32'(clear_o),    32'd0);
            tick();
            chk("nop_ready", 32'(req_ready),  32'd1);
        end

        // Reset during a clear phase.
        drive(1'b1, 2'b10, 2'b01, '0, 2'b00, 2'b00);
        tick();
        req_valid = 1'b0;
        tick();
        chk("ar_clear_pre", 32'(clear_o), 32'd1);
        #2;
        RST = 1'b1;
        model_reset();
        #1;
        chk("ar_clear", 32'(clear_o),    32'd0);
        chk("ar_busy",  32'(busy),       32'd0);
        chk("ar_ready", 32'(req_ready),  32'd1);
        chk("ar_done",  32'(done_pulse), 32'd0);
        @(posedge CLK);
        #1;
        chk("ar_done_hold", 32'(done_pulse), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        tick();
        chk("ar_after_done",  32'(done_pulse), 32'd0);
        chk("ar_after_ready", 32'(req_ready),  32'd1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom), 2'($urandom),
                  TW'($urandom_range(0, 5)),
                  {1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0)},
                  {1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0)});
            tick();
        end
        drive(1'b0, 2'b00, 2'b00, '0, 2'b11, 2'b11);
        for (int k = 0; k < 20 && busy; k++) tick();
        chk("rand_drain", 32'(busy), 32'd0);

        // Timeout disabled with a very long completion: counter must saturate quietly.
        drive(1'b1, 2'b01, 2'b01, '0, 2'b00, 2'b00);
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 70000; k++) tick();
        chk("long_flush", 32'(flush_o), 32'd1);
        flush_done_i = 2'b01;
        seen = 1'b0;
        for (int k = 0; k < 5 && !seen; k++) begin
            tick();
            if (done_pulse) seen = 1'b1;
        end
        chk("long_seen", 32'(seen),     32'd1);
        chk("long_err",  32'(err_mask), 32'd0);
        tick();

        run_cmp = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
